vga_line_fetch: RTL and testbench
=================================

// Module: vga_line_fetch
// PURPOSE
//  Downstream consumer of the row-address generator's o_wr_h/o_pos.
//  - Each o_wr_h pulse starts a burst fetch of one character row (RES_X_MAX codes) from text VRAM, beginning at o_pos.
//  - Codes go into the back half of a ping-pong line buffer.
//  - The pixel/font stage reads the front half by column while the next row is fetched.
// PARAMETERS
//  RES_X_MAX  8'd80  characters per text row (1..127)
//  RES_Y_MAX  8'd25  text rows per screen; VRAM depth = RES_X_MAX*RES_Y_MAX
// PORTS
//  i_clk         in   1   pixel-domain clock
//  i_rst         in   1   asynchronous, active-high reset
//  i_wr_h        in   1   fetch-start strobe (from o_wr_h), 1-cycle pulse
//  i_pos         in   11  VRAM row base address (from o_pos)
//  i_swap        in   1   1-cycle pulse at text-row boundary: exchange front/back buffers
//  o_vram_addr   out  11  VRAM read address
//  o_vram_rd     out  1   VRAM read enable
//  i_vram_data   in   8   VRAM read data, valid exactly 1 cycle after o_vram_rd
//  i_disp_col    in   7   display column being requested
//  o_disp_char   out  8   character code for i_disp_col, registered
//  o_busy        out  1   fetch in progress
//  o_done        out  1   1-cycle pulse: back buffer fully written
//  o_err         out  1   1-cycle pulse: i_wr_h while busy (start dropped)
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, idx=0, front_sel=0. Buffer contents undefined.
//  FSM states: IDLE -> FETCH -> DRAIN -> DONE -> IDLE.
//  IDLE:
//  - On i_wr_h: latch base = (i_pos >= RES_X_MAX*RES_Y_MAX) ? 0 : i_pos.
//  - Latch tgt = ~front_sel; set idx=0; go to FETCH.
//  FETCH, one read per cycle:
//  - o_vram_rd=1, o_vram_addr = base+idx (11-bit; no wrap needed since base is clamped and row-aligned).
//  - idx++; when idx==RES_X_MAX-1 is issued, go to DRAIN.
//  Write-back:
//  - Data returned in cycle k+1 is written to buf[tgt][k].
//  - DRAIN captures the last word, with o_vram_rd=0.
//  DONE: o_done=1 for one cycle; back to IDLE.
//  Timing:
//  - o_busy=1 in FETCH, DRAIN and DONE.
//  - i_wr_h at cycle t gives the first o_vram_rd at t+1 and o_done at t+RES_X_MAX+2.
//  - IDLE accepts a new i_wr_h in the same cycle o_done deasserts.
//  i_wr_h while o_busy: start ignored, o_err=1 for one cycle; the current fetch is unaffected.
//  i_swap:
//  - Toggles front_sel on the next edge, whatever the FSM state.
//  - An in-flight fetch keeps its latched tgt, so a swap mid-fetch displays a partially old row (legal, not flagged).
//  - i_swap together with i_wr_h in IDLE: tgt is computed from the pre-toggle front_sel, so the new row lands in the buffer that becomes front.
//  Display read:
//  - o_disp_char = buf[front_sel][i_disp_col], registered, 1-cycle latency.
//  - i_disp_col >= RES_X_MAX returns 8'h20 (space).
//  - Read/write port collision cannot occur because tgt != front_sel except after a mid-fetch swap; the read then returns old data (read-first).
//  Reset asserted mid-fetch: immediate abort to IDLE, o_vram_rd=0, no o_done.
// STRUCTURE
//  Shared include vga_config.vh:
//  - Resolution defines; VRAM_AW=11; CHAR_W=8; COL_W=7.
//  - Blank code 8'h20.
//  One sub-module, vga_line_buf_dp:
//  - Simple dual-port RAM of 2*RES_X_MAX x 8, maps to BSRAM.
//  - Write port {tgt,idx_d}; read port {front_sel,col}; registered, read-first.
//  Top holds the FSM, index/address counters and the 1-cycle write pipeline.
// TESTING
//  T1 Start:
//  - i_wr_h with i_pos=80, VRAM model data = addr[7:0].
//  - 80 reads at addresses 80..159, o_done 82 cycles later.
//  - After i_swap, col 0..79 read 8'h50..8'h9F.
//  T2 Clamp: i_pos=2000 (>=2000) -> fetch starts at address 0.
//  T3 Busy start: second i_wr_h 10 cycles into a fetch -> o_err pulse; exactly 80 reads, single o_done.
//  T4 Swap mid-fetch:
//  - i_swap at fetch cycle 40 -> tgt unchanged.
//  - Cols 0..39 show new data, cols 40..79 show old data.
//  T5 Display bounds: i_disp_col=80 and 127 -> o_disp_char=8'h20, one cycle after the column is presented.
//  T6 Reset: assert i_rst at fetch cycle 20 -> o_vram_rd/o_busy drop at once; no o_done; next i_wr_h completes normally.

Source files
------------

// File: rtl/vga_line_fetch_pkg.sv
// rtl/vga_line_fetch_pkg.sv - shared geometry, widths and FSM state type
// Purpose: text-mode geometry, bus widths and line-fetch FSM encoding.
// Ports: none (package).
package vga_line_fetch_pkg;
  localparam int RES_X_MAX = 80;  // characters per text row (1..127)
  localparam int RES_Y_MAX = 25;  // text rows per screen
  localparam int VRAM_AW   = 11;
  localparam int CHAR_W    = 8;
  localparam int COL_W     = 7;
  localparam int BUF_AW    = 8;   // addresses 2*RES_X_MAX entries
  localparam logic [CHAR_W-1:0] BLANK_CHAR = 8'h20;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;
endpackage

// File: rtl/vga_line_fetch_if.sv
// rtl/vga_line_fetch_if.sv - text VRAM read bus
// Purpose: groups the VRAM read request and its 1-cycle-latency read data.
// Ports: vram_addr/vram_rd driven by master, vram_data driven by slave.
interface vga_line_fetch_if;
  import vga_line_fetch_pkg::*;
  logic [VRAM_AW-1:0] vram_addr;
  logic               vram_rd;
  logic [CHAR_W-1:0]  vram_data;

  modport master (output vram_addr, output vram_rd, input vram_data);
  modport slave  (input vram_addr, input vram_rd, output vram_data);
endinterface

// File: rtl/vga_line_fetch_buf_dp.sv
// rtl/vga_line_fetch_buf_dp.sv - ping-pong line buffer, simple dual-port RAM
// Purpose: 2*RES_X_MAX x CHAR_W RAM; one write port, one registered read-first read port.
// Ports: clk/rst, write {wr_sel,wr_col,wr_data,wr_en}, read {rd_sel,rd_col} -> rd_data (1-cycle latency).
module vga_line_buf_dp
  import vga_line_fetch_pkg::*;
#(
  parameter int RES_X_MAX = vga_line_fetch_pkg::RES_X_MAX
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              wr_sel,
  input  logic [COL_W-1:0]  wr_col,
  input  logic [CHAR_W-1:0] wr_data,
  input  logic              rd_sel,
  input  logic [COL_W-1:0]  rd_col,
  output logic [CHAR_W-1:0] rd_data
);
  logic [CHAR_W-1:0] mem [2*RES_X_MAX];
  logic [BUF_AW-1:0] waddr, raddr;
  logic [CHAR_W-1:0] rd_data_d, rd_data_q;

  // Half select picks the upper or lower RES_X_MAX entries.
  assign waddr = (wr_sel ? BUF_AW'(RES_X_MAX) : '0) + BUF_AW'(wr_col);
  assign raddr = (rd_sel ? BUF_AW'(RES_X_MAX) : '0) + BUF_AW'(rd_col);

  always_ff @(posedge clk) begin
    if (wr_en) mem[waddr] <= wr_data;
  end

  always_comb begin
    rd_data_d = mem[raddr];
  end

  // Read register samples the pre-write contents on a same-address collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_data_q <= '0;
    else     rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;
endmodule

// File: rtl/vga_line_fetch.sv
// rtl/vga_line_fetch.sv - burst fetch of one text row into a ping-pong line buffer
// Purpose: on i_wr_h, read RES_X_MAX codes from VRAM starting at i_pos into the back
//   buffer; the display side reads the front buffer by column; i_swap exchanges halves.
// Ports: i_clk/i_rst, i_wr_h/i_pos fetch start, i_swap buffer exchange, vram (VRAM bus master),
//   i_disp_col -> o_disp_char (registered), o_busy/o_done/o_err status.
module vga_line_fetch
  import vga_line_fetch_pkg::*;
#(
  parameter int RES_X_MAX = vga_line_fetch_pkg::RES_X_MAX,
  parameter int RES_Y_MAX = vga_line_fetch_pkg::RES_Y_MAX
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_wr_h,
  input  logic [VRAM_AW-1:0] i_pos,
  input  logic               i_swap,
  vga_line_fetch_if.master   vram,
  input  logic [COL_W-1:0]   i_disp_col,
  output logic [CHAR_W-1:0]  o_disp_char,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_err
);
  localparam logic [COL_W-1:0]   LAST_IDX   = COL_W'(RES_X_MAX - 1);
  localparam logic [VRAM_AW:0]   VRAM_DEPTH = (VRAM_AW+1)'(RES_X_MAX * RES_Y_MAX);
  localparam logic [COL_W:0]     COL_LIMIT  = (COL_W+1)'(RES_X_MAX);

  state_t             state_q, state_d;
  logic [VRAM_AW-1:0] base_q, base_d;
  logic [COL_W-1:0]   idx_q, idx_d;
  logic               tgt_q, tgt_d;
  logic               front_sel_q, front_sel_d;
  logic               wr_en_q, wr_en_d;
  logic [COL_W-1:0]   wr_idx_q, wr_idx_d;
  logic               err_q, err_d;
  logic               oob_q, oob_d;
  logic               rd_en;
  logic               accept;
  logic [COL_W-1:0]   rd_col;
  logic [CHAR_W-1:0]  buf_rd_data;

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (i_wr_h) state_d = ST_FETCH;
      ST_FETCH: if (idx_q == LAST_IDX) state_d = ST_DRAIN;
      ST_DRAIN: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    rd_en  = (state_q == ST_FETCH);
    o_busy = (state_q != ST_IDLE);
    o_done = (state_q == ST_DONE);
  end

  assign accept         = (state_q == ST_IDLE) && i_wr_h;
  assign vram.vram_rd   = rd_en;
  assign vram.vram_addr = base_q + VRAM_AW'(idx_q);

  // Datapath: counters, buffer select and the 1-cycle write pipeline
  always_comb begin
    base_d = base_q;
    idx_d  = idx_q;
    tgt_d  = tgt_q;
    if (accept) begin
      base_d = ({1'b0, i_pos} >= VRAM_DEPTH) ? '0 : i_pos;
      tgt_d  = ~front_sel_q;  // pre-toggle select, so a coincident swap makes this row front
      idx_d  = '0;
    end else if (rd_en) begin
      idx_d = idx_q + 1'b1;
    end
    front_sel_d = front_sel_q ^ i_swap;
    wr_en_d     = rd_en;       // data for the read issued now arrives next cycle
    wr_idx_d    = idx_q;
    err_d       = i_wr_h && (state_q != ST_IDLE);
    oob_d       = ({1'b0, i_disp_col} >= COL_LIMIT);
    rd_col      = oob_d ? '0 : i_disp_col;  // keep the RAM index inside the array
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      base_q      <= '0;
      idx_q       <= '0;
      tgt_q       <= 1'b0;
      front_sel_q <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_idx_q    <= '0;
      err_q       <= 1'b0;
      oob_q       <= 1'b0;
    end else begin
      base_q      <= base_d;
      idx_q       <= idx_d;
      tgt_q       <= tgt_d;
      front_sel_q <= front_sel_d;
      wr_en_q     <= wr_en_d;
      wr_idx_q    <= wr_idx_d;
      err_q       <= err_d;
      oob_q       <= oob_d;
    end
  end

  vga_line_buf_dp #(.RES_X_MAX(RES_X_MAX)) u_buf (
    .clk     (i_clk),
    .rst     (i_rst),
    .wr_en   (wr_en_q),
    .wr_sel  (tgt_q),
    .wr_col  (wr_idx_q),
    .wr_data (vram.vram_data),
    .rd_sel  (front_sel_q),
    .rd_col  (rd_col),
    .rd_data (buf_rd_data)
  );

  assign o_disp_char = oob_q ? BLANK_CHAR : buf_rd_data;
  assign o_err       = err_q;
endmodule

// File: tb/tb_vga_line_fetch.sv
// tb/tb_vga_line_fetch.sv - self-checking bench for vga_line_fetch
module tb_vga_line_fetch;
  logic        clk = 1'b0;
  logic        rst;
  logic        wr_h;
  logic [10:0] pos;
  logic        swap;
  logic [6:0]  disp_col;
  logic [7:0]  disp_char;
  logic        busy, done, err;
  logic [7:0]  key;

  int n_cmp = 0;
  int n_bad = 0;

  logic [10:0] addr_log [0:1023];
  int rd_total = 0;
  int done_total = 0;
  int err_total = 0;

  typedef struct {
    logic [6:0] col;
    logic [7:0] exp;
  } disp_vec_t;

  vga_line_fetch_if vif ();

  vga_line_fetch dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_wr_h      (wr_h),
    .i_pos       (pos),
    .i_swap      (swap),
    .vram        (vif),
    .i_disp_col  (disp_col),
    .o_disp_char (disp_char),
    .o_busy      (busy),
    .o_done      (done),
    .o_err       (err)
  );

  always #5 clk = ~clk;

  // VRAM model: data = addr[7:0] ^ key, one cycle after the read
  always @(posedge clk) begin
    if (vif.vram_rd) vif.vram_data <= vif.vram_addr[7:0] ^ key;
    else             vif.vram_data <= 8'hEE;
  end

  always @(negedge clk) begin
    if (vif.vram_rd) begin
      if (rd_total < 1024) addr_log[rd_total] = vif.vram_addr;
      rd_total++;
    end
    if (done) done_total++;
    if (err)  err_total++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_fetch(input logic [10:0] p, output int lat);
    pos  = p;
    wr_h = 1'b1;
    tick();
    wr_h = 1'b0;
    lat  = 1;
    while (!done && lat < 300) begin
      tick();
      lat++;
    end
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 300) begin
      tick();
      n++;
    end
    check(name, {31'd0, done}, 32'd1);
  endtask

  task automatic pulse_swap();
    swap = 1'b1;
    tick();
    swap = 1'b0;
  endtask

  task automatic read_col(input string name, input logic [6:0] c, input logic [7:0] exp);
    disp_col = c;
    tick();
    check(name, {24'd0, disp_char}, {24'd0, exp});
  endtask

  task automatic check_addrs(input string name, input int s, input int base);
    int bad = 0;
    for (int i = 0; i < 80; i++)
      if (s + i >= 1024 || addr_log[s+i] != 11'(base + i)) bad++;
    check(name, bad, 0);
  endtask

  initial begin
    disp_vec_t vecs [8];
    int lat, s, d0, e0;

    vecs[0] = '{7'd0,   8'h50};
    vecs[1] = '{7'd1,   8'h51};
    vecs[2] = '{7'd40,  8'h78};
    vecs[3] = '{7'd80,  8'h20};
    vecs[4] = '{7'd79,  8'h9F};
    vecs[5] = '{7'd127, 8'h20};
    vecs[6] = '{7'd5,   8'h55};
    vecs[7] = '{7'd64,  8'h90};

    rst = 1'b1; wr_h = 1'b0; pos = '0; swap = 1'b0; disp_col = '0; key = 8'h00;
    tick(); tick();
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_err",  {31'd0, err}, 0);
    check("rst_rd",   {31'd0, vif.vram_rd}, 0);
    check("rst_char", {24'd0, disp_char}, 0);
    rst = 1'b0;
    tick();

    // T1: start at row 1, then swap and read via vector table
    s = rd_total;
    run_fetch(11'd80, lat);
    check("t1_latency", lat, 82);
    check("t1_reads", rd_total - s, 80);
    check_addrs("t1_addrs", s, 80);
    pulse_swap();
    for (int i = 0; i < 8; i++)
      read_col($sformatf("t1_disp[%0d]", vecs[i].col), vecs[i].col, vecs[i].exp);

    // T2: out-of-range base clamps to 0
    s = rd_total;
    run_fetch(11'd2000, lat);
    check("t2_latency", lat, 82);
    check("t2_reads", rd_total - s, 80);
    check_addrs("t2_addrs", s, 0);
    pulse_swap();
    read_col("t2_col0", 7'd0, 8'h00);
    read_col("t2_col79", 7'd79, 8'h4F);

    // T3: second start while busy is dropped and flagged
    s = rd_total; d0 = done_total; e0 = err_total;
    pos = 11'd160; wr_h = 1'b1; tick(); wr_h = 1'b0;
    repeat (10) tick();
    pos = 11'd400; wr_h = 1'b1; tick(); wr_h = 1'b0;
    wait_done("t3_done_seen");
    repeat (3) tick();
    check("t3_err", err_total - e0, 1);
    check("t3_dones", done_total - d0, 1);
    check("t3_reads", rd_total - s, 80);
    check_addrs("t3_addrs", s, 160);

    // T4: swap mid-fetch leaves tgt alone; front shows partial row
    key = 8'hFF;
    pos = 11'd240; wr_h = 1'b1; tick(); wr_h = 1'b0;
    repeat (40) tick();
    pulse_swap();
    read_col("t4_mid_col0_new", 7'd0, 8'h0F);
    read_col("t4_mid_col79_old", 7'd79, 8'hEF);
    wait_done("t4_done_seen");
    tick();
    read_col("t4_col79_new", 7'd79, 8'hC0);
    read_col("t4_col40_new", 7'd40, 8'hE7);
    pulse_swap();
    read_col("t4_other_buf", 7'd5, 8'h05);

    // T6: reset mid-fetch aborts, next fetch is normal
    key = 8'h00;
    d0 = done_total;
    pos = 11'd400; wr_h = 1'b1; tick(); wr_h = 1'b0;
    repeat (19) tick();
    check("t6_rd_before", {31'd0, vif.vram_rd}, 1);
    rst = 1'b1;
    #1;
    check("t6_rd_abort", {31'd0, vif.vram_rd}, 0);
    check("t6_busy_abort", {31'd0, busy}, 0);
    tick();
    rst = 1'b0;
    repeat (90) tick();
    check("t6_no_done", done_total - d0, 0);
    s = rd_total;
    run_fetch(11'd80, lat);
    check("t6_latency", lat, 82);
    check("t6_reads", rd_total - s, 80);
    check_addrs("t6_addrs", s, 80);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
